id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_id_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: decodes instr_i, selects ALU operands, registers the bundle for execute.
// Latency: one cycle from accepted instruction to out_valid_o; rs1/rs2 addresses are combinational.
// Backpressure: in_ready_o = !out_valid_o | out_ready_i; a stalled bundle holds every output stable.
// Ports: clk_i/rst_ni (async active-low); in_valid_i/in_ready_o/instr_i/pc_i from fetch;
//        rs*_addr_o/rs*_data_i to/from the register file; flush_i kills held and incoming;
//        out_valid_o/out_ready_i plus alu_a/b/op, imm, pc, rd, control flags to execute.
module id_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_op_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic        branch_o,
  output logic        branch_inv_o,
  output logic        jump_o,
  output logic        illegal_o
);

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_LT   = 4'd3;
  localparam logic [3:0] ALU_LTU  = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_EQ   = 4'd10, ALU_GTE  = 4'd11;
  localparam logic [3:0] ALU_GTEU = 4'd12, ALU_JALR = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111, OPC_JAL   = 7'b1101111, OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011, OPC_STORE = 7'b0100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000, F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        branch_inv;
    logic        jump;
    logic        illegal;
  } bundle_t;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  bundle_t     dec;
  logic        dec_wr;
  logic        xfer;
  bundle_t     bundle_d, bundle_q;
  logic        out_valid_d, out_valid_q;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};
  assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign shamt = {27'd0, instr_i[24:20]};

  // Decode. dec_wr marks formats that architecturally write rd; the x0 filter is applied afterwards.
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.pc     = pc_i;
    dec_wr     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.alu_a = rs1_data_i;
        dec.alu_b = rs2_data_i;
        dec_wr    = 1'b1;
        case ({funct7, funct3})
          {F7_ZERO, 3'b000}: dec.alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: dec.alu_op = ALU_SUB;
          {F7_ZERO, 3'b001}: dec.alu_op = ALU_SLL;
          {F7_ZERO, 3'b010}: dec.alu_op = ALU_LT;
          {F7_ZERO, 3'b011}: dec.alu_op = ALU_LTU;
          {F7_ZERO, 3'b100}: dec.alu_op = ALU_XOR;
          {F7_ZERO, 3'b101}: dec.alu_op = ALU_SRL;
          {F7_ALT,  3'b101}: dec.alu_op = ALU_SRA;
          {F7_ZERO, 3'b110}: dec.alu_op = ALU_OR;
          {F7_ZERO, 3'b111}: dec.alu_op = ALU_AND;
          default:           dec.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.alu_a = rs1_data_i;
        dec.alu_b = imm_i;
        dec.imm   = imm_i;
        dec_wr    = 1'b1;
        case (funct3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_LT;
          3'b011: dec.alu_op = ALU_LTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_b   = shamt;
            dec.alu_op  = ALU_SLL;
            dec.illegal = (funct7 != F7_ZERO);
          end
          default: begin  // 3'b101: SRLI / SRAI picked by funct7
            dec.alu_b   = shamt;
            dec.alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec.alu_b = imm_u;
        dec.imm   = imm_u;
        dec_wr    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_a = pc_i;
        dec.alu_b = imm_u;
        dec.imm   = imm_u;
        dec_wr    = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_a = pc_i;
        dec.alu_b = 32'd4;
        dec.imm   = imm_j;
        dec.jump  = 1'b1;
        dec_wr    = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_a   = rs1_data_i;
        dec.alu_b   = imm_i;
        dec.imm     = imm_i;
        dec.alu_op  = ALU_JALR;
        dec.jump    = 1'b1;
        dec_wr      = 1'b1;
        dec.illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.alu_a  = rs1_data_i;
        dec.alu_b  = rs2_data_i;
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (funct3)
          3'b000: dec.alu_op = ALU_EQ;
          3'b001: begin
            dec.alu_op     = ALU_EQ;
            dec.branch_inv = 1'b1;
          end
          3'b100: dec.alu_op = ALU_LT;
          3'b101: dec.alu_op = ALU_GTE;
          3'b110: dec.alu_op = ALU_LTU;
          3'b111: dec.alu_op = ALU_GTEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.alu_a   = rs1_data_i;
        dec.alu_b   = imm_i;
        dec.imm     = imm_i;
        dec.mem_re  = 1'b1;
        dec_wr      = 1'b1;
        // Legal widths: LB LH LW LBU LHU
        dec.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.alu_a   = rs1_data_i;
        dec.alu_b   = imm_s;
        dec.imm     = imm_s;
        dec.mem_we  = 1'b1;
        // Legal widths: SB SH SW
        dec.illegal = funct3[2] || (funct3[1:0] == 2'b11);
      end
      default: dec.illegal = 1'b1;
    endcase

    // An illegal word carries no operands or side effects; only pc and the illegal flag survive.
    if (dec.illegal) begin
      dec         = '0;
      dec.alu_op  = ALU_ADD;
      dec.pc      = pc_i;
      dec.illegal = 1'b1;
      dec_wr      = 1'b0;
    end
    dec.rd_addr = dec_wr ? rd : 5'd0;
    dec.rd_we   = dec_wr && (rd != 5'd0);
  end

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign xfer       = in_valid_i && in_ready_o && !flush_i;

  // Fields only load on a transfer, so a stalled bundle is frozen by construction.
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign alu_a_o      = bundle_q.alu_a;
  assign alu_b_o      = bundle_q.alu_b;
  assign alu_op_o     = bundle_q.alu_op;
  assign imm_o        = bundle_q.imm;
  assign pc_o         = bundle_q.pc;
  assign rd_addr_o    = bundle_q.rd_addr;
  assign rd_we_o      = bundle_q.rd_we;
  assign mem_re_o     = bundle_q.mem_re;
  assign mem_we_o     = bundle_q.mem_we;
  assign branch_o     = bundle_q.branch;
  assign branch_inv_o = bundle_q.branch_inv;
  assign jump_o       = bundle_q.jump;
  assign illegal_o    = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: scoreboard of expected bundles fed by the stimulus process,
// popped by an independent monitor; expectations come from a mnemonic-level RV32I model.
// Directed cases for the documented examples, stall, flush and reset, then random traffic.
module tb_id_stage;

  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_LT = 3, A_LTU = 4, A_XOR = 5, A_SRL = 6;
  localparam int A_SRA = 7, A_OR = 8, A_AND = 9, A_EQ = 10, A_GTE = 11, A_GTEU = 12, A_JALR = 13;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we, mem_re, mem_we, br, inv, jmp, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni, in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] alu_a_o, alu_b_o, imm_o, pc_o;
  logic [3:0]  alu_op_o;
  logic        rd_we_o, mem_re_o, mem_we_o, branch_o, branch_inv_o, jump_o, illegal_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic mdl_vld = 1'b0;
  logic mdl_nxt = 1'b0;

  string r_names [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
  string i_names [8] = '{"ADDI", "ILL", "SLTI", "SLTIU", "XORI", "ILL", "ORI", "ANDI"};
  string b_names [8] = '{"BEQ", "BNE", "ILL", "ILL", "BLT", "BGE", "BLTU", "BGEU"};
  string l_names [8] = '{"LB", "LH", "LW", "ILL", "LBU", "LHU", "ILL", "ILL"};
  logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h73};

  id_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_op_o(alu_op_o), .imm_o(imm_o), .pc_o(pc_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .branch_o(branch_o), .branch_inv_o(branch_inv_o),
    .jump_o(jump_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic exp_t dut_bundle();
    return {alu_a_o, alu_b_o, alu_op_o, imm_o, pc_o, rd_addr_o, rd_we_o, mem_re_o, mem_we_o,
            branch_o, branch_inv_o, jump_o, illegal_o};
  endfunction

  // Two's-complement interpretation of an n-bit field, as plain arithmetic.
  function automatic logic [31:0] sext(input longint v, input int n);
    longint x = v;
    if (x >= (longint'(1) << (n - 1))) x = x - (longint'(1) << n);
    return x[31:0];
  endfunction

  function automatic string classify(input logic [31:0] ins);
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    case (ins[6:0])
      7'h33: begin
        if (f7 == 0) return r_names[f3];
        if (f7 == 32 && f3 == 0) return "SUB";
        if (f7 == 32 && f3 == 5) return "SRA";
        return "ILL";
      end
      7'h13: begin
        if (f3 == 1) begin
          if (f7 == 0) return "SLLI";
          return "ILL";
        end
        if (f3 == 5) begin
          if (f7 == 0) return "SRLI";
          if (f7 == 32) return "SRAI";
          return "ILL";
        end
        return i_names[f3];
      end
      7'h37: return "LUI";
      7'h17: return "AUIPC";
      7'h6f: return "JAL";
      7'h67: begin
        if (f3 == 0) return "JALR";
        return "ILL";
      end
      7'h63: return b_names[f3];
      7'h03: return l_names[f3];
      7'h23: begin
        if (f3 < 3) return "STORE";
        return "ILL";
      end
      default: return "ILL";
    endcase
  endfunction

  function automatic int alu_code(input string n);
    case (n)
      "SUB":                 return A_SUB;
      "SLL", "SLLI":         return A_SLL;
      "SLT", "SLTI", "BLT":  return A_LT;
      "SLTU", "SLTIU", "BLTU": return A_LTU;
      "XOR", "XORI":         return A_XOR;
      "SRL", "SRLI":         return A_SRL;
      "SRA", "SRAI":         return A_SRA;
      "OR", "ORI":           return A_OR;
      "AND", "ANDI":         return A_AND;
      "BEQ", "BNE":          return A_EQ;
      "BGE":                 return A_GTE;
      "BGEU":                return A_GTEU;
      "JALR":                return A_JALR;
      default:               return A_ADD;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, pc, r1, r2);
    exp_t        e;
    string       n;
    logic        wr;
    logic [31:0] ii, si, bi, ui, ji;
    n  = classify(ins);
    ii = sext(longint'(ins[31:20]), 12);
    si = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
    bi = sext(longint'(ins[31]) * 2048 + longint'(ins[7]) * 1024 + longint'(ins[30:25]) * 16
              + longint'(ins[11:8]), 12) * 2;
    ui = ins[31:12] * 4096;
    ji = sext(longint'(ins[31]) * 524288 + longint'(ins[19:12]) * 2048 + longint'(ins[20]) * 1024
              + longint'(ins[30:21]), 20) * 2;
    e    = '0;
    e.pc = pc;
    wr   = 1'b0;
    case (n)
      "ADD", "SUB", "SLL", "SLT", "SLTU", "XOR", "SRL", "SRA", "OR", "AND": begin
        e.a = r1; e.b = r2; wr = 1'b1;
      end
      "ADDI", "SLTI", "SLTIU", "XORI", "ORI", "ANDI", "JALR": begin
        e.a = r1; e.b = ii; e.imm = ii; wr = 1'b1; e.jmp = (n == "JALR");
      end
      "SLLI", "SRLI", "SRAI": begin
        e.a = r1; e.b = 32'(ins[24:20]); e.imm = ii; wr = 1'b1;
      end
      "LUI":   begin e.b = ui; e.imm = ui; wr = 1'b1; end
      "AUIPC": begin e.a = pc; e.b = ui; e.imm = ui; wr = 1'b1; end
      "JAL":   begin e.a = pc; e.b = 4; e.imm = ji; e.jmp = 1'b1; wr = 1'b1; end
      "BEQ", "BNE", "BLT", "BGE", "BLTU", "BGEU": begin
        e.a = r1; e.b = r2; e.imm = bi; e.br = 1'b1; e.inv = (n == "BNE");
      end
      "LB", "LH", "LW", "LBU", "LHU": begin
        e.a = r1; e.b = ii; e.imm = ii; e.mem_re = 1'b1; wr = 1'b1;
      end
      "STORE": begin e.a = r1; e.b = si; e.imm = si; e.mem_we = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    e.op = 4'(alu_code(n));
    if (wr) begin
      e.rd    = ins[11:7];
      e.rd_we = (ins[11:7] != 5'd0);
    end
    return e;
  endfunction

  // One cycle of stimulus: drive at negedge+1, predict acceptance, push the expected bundle.
  task automatic cycle(input logic v, input logic [31:0] ins, pc, r1, r2, input logic fl, rdy);
    logic xfer;
    @(negedge clk);
    #1;
    mdl_vld     = mdl_nxt;
    in_valid_i  = v;
    instr_i     = ins;
    pc_i        = pc;
    rs1_data_i  = r1;
    rs2_data_i  = r2;
    flush_i     = fl;
    out_ready_i = rdy;
    xfer        = v && (!mdl_vld || rdy) && !fl;
    if (xfer) sb.push_back(model(ins, pc, r1, r2));
    mdl_nxt = fl ? 1'b0 : (xfer ? 1'b1 : (rdy ? 1'b0 : mdl_vld));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int          k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: between edges, compare the presented bundle against the scoreboard head.
  initial begin
    exp_t got;
    forever begin
      @(negedge clk);
      #3;
      if (rst_ni) begin
        check("in_ready", 144'(in_ready_o), 144'(!mdl_vld || out_ready_i));
        check("out_valid", 144'(out_valid_o), 144'(mdl_vld));
        check("rs_addr", 144'({rs1_addr_o, rs2_addr_o}), 144'({instr_i[19:15], instr_i[24:20]}));
        if (mdl_vld) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 144'(sb.size()), 144'(1));
          end else begin
            got = dut_bundle();
            check("bundle", got, sb[0]);
            if (out_ready_i || flush_i) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; instr_i = '0; pc_i = '0; rs1_data_i = '0;
    rs2_data_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    #3;
    check("reset_valid", 144'(out_valid_o), 144'(0));
    check("reset_ready", 144'(in_ready_o), 144'(1));
    check("reset_fields", dut_bundle(), 144'(0));
    #9 rst_ni = 1'b1;

    // ADD x3,x1,x2
    cycle(1'b1, 32'h002081B3, 32'h100, 32'd42, 32'd1337, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("add_fields", {out_valid_o, alu_a_o, alu_b_o, alu_op_o, rd_addr_o, rd_we_o},
          {1'b1, 32'd42, 32'd1337, 4'(A_ADD), 5'd3, 1'b1});
    // SRAI x5,x6,2
    cycle(1'b1, 32'h40235293, 32'h104, 32'hFFFFFFF8, 32'h5, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("srai_fields", {alu_a_o, alu_b_o, alu_op_o, rd_addr_o},
          {32'hFFFFFFF8, 32'd2, 4'(A_SRA), 5'd5});
    // BNE x1,x2,+8
    cycle(1'b1, 32'h00209463, 32'h108, 32'd7, 32'd9, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("bne_fields", {alu_op_o, branch_o, branch_inv_o, imm_o, rd_we_o},
          {4'(A_EQ), 1'b1, 1'b1, 32'd8, 1'b0});
    // All-ones word
    cycle(1'b1, 32'hFFFFFFFF, 32'h10C, 32'h11, 32'h22, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("illegal_fields", {illegal_o, rd_we_o, mem_re_o, mem_we_o, alu_a_o, alu_b_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});

    // Stall three cycles with a new instruction waiting, then release.
    cycle(1'b1, 32'h00A00093, 32'h200, 32'd1, 32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h00308133, 32'h204, 32'd5, 32'd6, 1'b0, 1'b0);
      #1;
      check("stall_in_ready", 144'(in_ready_o), 144'(0));
    end
    cycle(1'b1, 32'h00308133, 32'h204, 32'd5, 32'd6, 1'b0, 1'b1);
    #1;
    check("release_in_ready", 144'(in_ready_o), 144'(1));

    // Flush beats an incoming instruction.
    cycle(1'b1, 32'h00108093, 32'h208, 32'd3, 32'd4, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("flush_valid", 144'(out_valid_o), 144'(0));

    // Asynchronous reset while a bundle is stalled.
    cycle(1'b1, 32'h00208033, 32'h20C, 32'hDEADBEEF, 32'h1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_valid", 144'(out_valid_o), 144'(0));
    check("arst_fields", {in_ready_o, alu_a_o, pc_o}, {1'b1, 32'd0, 32'd0});
    sb.delete();
    mdl_vld = 1'b0;
    mdl_nxt = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    #2 rst_ni = 1'b1;

    // Random traffic; first transfer lands right after reset release.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFFFFFC, $urandom, $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #4;
    check("sb_drained", 144'(sb.size()), 144'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
